// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX and TX paths.
//   - frame state encoding (2-bit)
//   - data width
//   - bit-timing helper functions derived from clock frequency and line rate
package uart_pkg;

    localparam int unsigned DATA_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t START = 2'd1;
    localparam state_t DATA  = 2'd2;
    localparam state_t STOP  = 2'd3;

    // Clocks per bit, integer floor.
    function automatic int unsigned calc_bit_cnt(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // Clocks from the start edge to the start-bit centre.
    function automatic int unsigned calc_half_cnt(input int unsigned clk_freq,
                                                  input int unsigned baud);
        return calc_bit_cnt(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_bps_module.sv
// Clearable baud counter for the UART receiver.
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   clear       restart the count from zero (state entry)
//   run         count enable; counter held at zero while low
//   half_tick   count == HALF_CNT-1
//   full_tick   count == BIT_CNT-1 (counter wraps to zero)
module uart_rx_bps_module #(
    parameter int unsigned BIT_CNT  = 434,
    parameter int unsigned HALF_CNT = 217
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear,
    input  logic run,
    output logic half_tick,
    output logic full_tick
);

    localparam int unsigned CNT_W = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        half_tick = (cnt_q == CNT_W'(HALF_CNT - 1));
        full_tick = (cnt_q == CNT_W'(BIT_CNT - 1));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (clear || !run || full_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_frame_module.sv
// UART 8N1 receive frame engine.
// Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   RX_Pin_In    serial line (asynchronous, idle high)
//   RX_En_Sig    receiver enable; low aborts any frame and holds IDLE
//   RX_Data      last correctly framed byte
//   RX_Done_Sig  one-cycle pulse, new byte on RX_Data
//   RX_Err_Sig   one-cycle pulse, stop bit sampled low
//   RX_Busy      high whenever not IDLE
module uart_rx_frame_module
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RX_Pin_In,
    input  logic              RX_En_Sig,
    output logic [DATA_W-1:0] RX_Data,
    output logic              RX_Done_Sig,
    output logic              RX_Err_Sig,
    output logic              RX_Busy
);

    localparam int unsigned BIT_CNT  = calc_bit_cnt(CLK_FREQ, BAUD);
    localparam int unsigned HALF_CNT = calc_half_cnt(CLK_FREQ, BAUD);

    logic sync1_q, sync2_q, sync3_q;
    logic line, start_edge;

    state_t state_q, state_d;
    logic [2:0]        bit_idx_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] data_q;
    logic              done_q, err_q;
    logic              done_d, err_d, shift_en;
    logic              cnt_clear, cnt_run, half_tick, full_tick;

    // Two flops for metastability, a third only to see the falling edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= RX_Pin_In;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign line       = sync2_q;
    assign start_edge = sync3_q & ~sync2_q;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (!RX_En_Sig) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (start_edge) state_d = START;
                START: if (half_tick) state_d = line ? IDLE : DATA;
                DATA:  if (full_tick && bit_idx_q == 3'd7) state_d = STOP;
                STOP:  if (full_tick) state_d = IDLE;
            endcase
        end
    end

    // Output / datapath strobes.
    always_comb begin
        cnt_clear = (state_d != state_q);
        cnt_run   = (state_q != IDLE);
        shift_en  = RX_En_Sig && (state_q == DATA) && full_tick;
        done_d    = RX_En_Sig && (state_q == STOP) && full_tick && line;
        err_d     = RX_En_Sig && (state_q == STOP) && full_tick && !line;
        RX_Busy   = (state_q != IDLE);
    end

    uart_rx_bps_module #(
        .BIT_CNT  (BIT_CNT),
        .HALF_CNT (HALF_CNT)
    ) u_bps (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .clear     (cnt_clear),
        .run       (cnt_run),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
            if (shift_en) begin
                shift_q[bit_idx_q] <= line;
                bit_idx_q          <= bit_idx_q + 3'd1;
            end else if (state_q != DATA) begin
                bit_idx_q <= '0;
            end
            if (done_d) begin
                data_q <= shift_q;
            end
        end
    end

    assign RX_Data     = data_q;
    assign RX_Done_Sig = done_q;
    assign RX_Err_Sig  = err_q;

endmodule

// File: tb/tb_uart_rx_frame_module.sv
module tb_uart_rx_frame_module;

    localparam int unsigned BIT = 434;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pin = 1'b1;
    logic       en = 1'b1;
    logic [7:0] rx_data;
    logic       done, err, busy;

    always #10 clk = ~clk;

    uart_rx_frame_module #(
        .CLK_FREQ (50000000),
        .BAUD     (115200)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .RX_Pin_In   (pin),
        .RX_En_Sig   (en),
        .RX_Data     (rx_data),
        .RX_Done_Sig (done),
        .RX_Err_Sig  (err),
        .RX_Busy     (busy)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cycle = 0;
    int unsigned last_done_cycle = 0;
    int unsigned busy_total = 0;

    always @(posedge clk) cycle <= cycle + 1;
    always @(negedge clk) if (busy === 1'b1) busy_total++;

    // Scoreboard monitor: every Done/Err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1 || err === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: done=%0b err=%0b data=%02h, none expected",
                         done, err, rx_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (done !== !mon_e.is_err || err !== mon_e.is_err ||
                    (!mon_e.is_err && rx_data !== mon_e.data)) begin
                    n_fail++;
                    $display("FAIL event: got done=%0b err=%0b data=%02h, need done=%0b err=%0b data=%02h",
                             done, err, rx_data, !mon_e.is_err, mon_e.is_err, mon_e.data);
                end
            end
            if (done === 1'b1) last_done_cycle = cycle;
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 90000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic hold(input logic v, input int n);
        pin = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
        hold(stop, BIT);
    endtask

    task automatic push(input bit is_err, input logic [7:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected events still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int unsigned t0, d1, b0;
        logic [7:0] f;

        repeat (3) @(negedge clk);
        check("reset_data", rx_data, 8'h00);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single frame and its latency.
        push(0, 8'h55);
        t0 = cycle;
        send_frame(8'h55, 1'b1);
        wait_drain("frame_55", 500);
        check_range("latency_55", int'(last_done_cycle - t0), 4120, 4132);
        check("data_hold_55", rx_data, 8'h55);

        // Back-to-back frames.
        push(0, 8'hA5);
        push(0, 8'h3C);
        send_frame(8'hA5, 1'b1);
        d1 = last_done_cycle;
        check("data_a5", rx_data, 8'hA5);
        send_frame(8'h3C, 1'b1);
        wait_drain("frame_3c", 500);
        check_range("b2b_spacing", int'(last_done_cycle - d1), 4338, 4342);
        check("data_3c", rx_data, 8'h3C);
        repeat (50) @(negedge clk);

        // Short low glitch: false start.
        b0 = busy_total;
        hold(1'b0, 100);
        hold(1'b1, 500);
        check_range("glitch_busy_cycles", int'(busy_total - b0), 215, 219);
        check("glitch_data", rx_data, 8'h3C);

        // Framing error, then line stuck low.
        push(1, 8'h00);
        send_frame(8'hF0, 1'b0);
        wait_drain("frame_err", 500);
        check("err_data_kept", rx_data, 8'h3C);
        b0 = busy_total;
        hold(1'b0, 2000);
        check("stuck_low_busy", busy_total - b0, 0);
        hold(1'b1, 20);

        // Reset in the middle of data bit 4.
        f = 8'h81;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(f[i], BIT);
        hold(f[4], 200);
        check("mid_frame_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_data", rx_data, 8'h00);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        repeat (2) @(negedge clk);
        pin = 1'b1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        push(0, 8'h81);
        send_frame(8'h81, 1'b1);
        wait_drain("frame_81", 500);
        check("data_81", rx_data, 8'h81);

        // Enable dropped during data bit 2.
        f = 8'h5A;
        hold(1'b0, BIT);
        hold(f[0], BIT);
        hold(f[1], BIT);
        hold(f[2], 100);
        check("en_busy_before", busy, 1'b1);
        en = 1'b0;
        @(negedge clk);
        check("en_drop_idle", busy, 1'b0);
        hold(f[2], BIT - 101);
        for (int i = 3; i < 8; i++) hold(f[i], BIT);
        hold(1'b1, BIT);
        b0 = busy_total;
        send_frame(8'h5A, 1'b1);
        hold(1'b1, 50);
        check("en_off_busy", busy_total - b0, 0);
        check("en_off_data", rx_data, 8'h81);

        // Re-enabled receiver works again.
        en = 1'b1;
        repeat (20) @(negedge clk);
        push(0, 8'hC3);
        send_frame(8'hC3, 1'b1);
        wait_drain("frame_c3", 500);
        check("data_c3", rx_data, 8'hC3);
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
